// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - direct-mapped write-back/write-allocate data cache controller
// Optional hit/miss/write-back counters are built when DCACHE_STATS_EN is defined.
module dcache_ctrl #(
  parameter int SET_BITS    = 4,
  parameter int OFFSET_BITS = 2
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] cpu_addr_i,
  input  logic        cpu_rd_i,
  input  logic        cpu_wr_i,
  input  logic [31:0] cpu_wdata_i,
  input  logic [3:0]  cpu_be_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ack_i,
  output logic [31:0] cpu_rdata_o,
`ifdef DCACHE_STATS_EN
  output logic [31:0] hit_cnt_o,
  output logic [31:0] miss_cnt_o,
  output logic [31:0] wb_cnt_o,
`endif
  output logic        dcache_miss_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o
);

  localparam int TAG_BITS = 32 - 2 - OFFSET_BITS - SET_BITS;
  localparam int SETS     = 1 << SET_BITS;
  localparam int WORDS    = 1 << OFFSET_BITS;

  typedef enum logic [1:0] {IDLE, WB, FILL, DONE} state_e;

  state_e                 state_q;
  logic [SETS-1:0]        valid_q;
  logic [SETS-1:0]        dirty_q;
  logic [TAG_BITS-1:0]    tag_q  [SETS];
  logic [31:0]            data_q [SETS][WORDS];

  logic [SET_BITS-1:0]    miss_idx_q;
  logic [TAG_BITS-1:0]    old_tag_q;
  logic [TAG_BITS-1:0]    new_tag_q;
  logic [OFFSET_BITS-1:0] beat_q;
  logic [OFFSET_BITS-1:0] beat_d;

  logic                   mem_req_q;
  logic                   mem_we_q;
  logic [31:0]            mem_addr_q;
  logic [31:0]            mem_wdata_q;

  logic [OFFSET_BITS-1:0] req_word;
  logic [SET_BITS-1:0]    req_idx;
  logic [TAG_BITS-1:0]    req_tag;
  logic                   req;
  logic                   hit;
  logic                   idle_hit;
  logic                   last_beat;
  logic                   addr_unused;

  assign req_word    = cpu_addr_i[OFFSET_BITS+1:2];
  assign req_idx     = cpu_addr_i[OFFSET_BITS+SET_BITS+1:OFFSET_BITS+2];
  assign req_tag     = cpu_addr_i[31:OFFSET_BITS+SET_BITS+2];
  assign addr_unused = ^cpu_addr_i[1:0];

  assign req       = cpu_rd_i | cpu_wr_i;
  assign hit       = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign idle_hit  = (state_q == IDLE) && req && hit;
  assign last_beat = &beat_q;
  assign beat_d    = beat_q + 1'b1;

  assign dcache_miss_o = req && !((state_q == IDLE) && hit);
  assign cpu_rdata_o   = data_q[req_idx][req_word];

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

  function automatic logic [31:0] line_addr(input logic [TAG_BITS-1:0]    tag,
                                            input logic [SET_BITS-1:0]    idx,
                                            input logic [OFFSET_BITS-1:0] beat);
    return {tag, idx, beat, 2'b00};
  endfunction

  // Memory-side outputs are registered and only move on an ack, so they hold
  // steady for the whole of a stretched beat.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      dirty_q     <= '0;
      miss_idx_q  <= '0;
      old_tag_q   <= '0;
      new_tag_q   <= '0;
      beat_q      <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (idle_hit) begin
            if (cpu_wr_i) dirty_q[req_idx] <= 1'b1;
          end else if (req) begin
            miss_idx_q <= req_idx;
            old_tag_q  <= tag_q[req_idx];
            new_tag_q  <= req_tag;
            beat_q     <= '0;
            mem_req_q  <= 1'b1;
            if (valid_q[req_idx] && dirty_q[req_idx]) begin
              state_q     <= WB;
              mem_we_q    <= 1'b1;
              mem_addr_q  <= line_addr(tag_q[req_idx], req_idx, '0);
              mem_wdata_q <= data_q[req_idx][0];
            end else begin
              state_q    <= FILL;
              mem_we_q   <= 1'b0;
              mem_addr_q <= line_addr(req_tag, req_idx, '0);
            end
          end
        end
        WB: begin
          if (mem_ack_i) begin
            beat_q <= beat_d;
            if (last_beat) begin
              dirty_q[miss_idx_q] <= 1'b0;
              state_q             <= FILL;
              mem_we_q            <= 1'b0;
              mem_addr_q          <= line_addr(new_tag_q, miss_idx_q, '0);
            end else begin
              mem_addr_q  <= line_addr(old_tag_q, miss_idx_q, beat_d);
              mem_wdata_q <= data_q[miss_idx_q][beat_d];
            end
          end
        end
        FILL: begin
          if (mem_ack_i) begin
            beat_q <= beat_d;
            if (last_beat) begin
              valid_q[miss_idx_q] <= 1'b1;
              dirty_q[miss_idx_q] <= 1'b0;
              state_q             <= DONE;
              mem_req_q           <= 1'b0;
            end else begin
              mem_addr_q <= line_addr(new_tag_q, miss_idx_q, beat_d);
            end
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Tag and line storage carry no reset; the valid bits gate their use.
  always_ff @(posedge clk_i) begin
    if (idle_hit && cpu_wr_i) begin
      for (int b = 0; b < 4; b++) begin
        if (cpu_be_i[b]) data_q[req_idx][req_word][8*b +: 8] <= cpu_wdata_i[8*b +: 8];
      end
    end
    if ((state_q == FILL) && mem_ack_i) begin
      data_q[miss_idx_q][beat_q] <= mem_rdata_i;
      if (last_beat) tag_q[miss_idx_q] <= new_tag_q;
    end
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;
  logic [31:0] wb_cnt_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      wb_cnt_q   <= '0;
    end else begin
      if (idle_hit && (hit_cnt_q != '1)) hit_cnt_q <= hit_cnt_q + 32'd1;
      if ((state_q == IDLE) && req && !hit && (miss_cnt_q != '1)) miss_cnt_q <= miss_cnt_q + 32'd1;
      if ((state_q == WB) && mem_ack_i && last_beat && (wb_cnt_q != '1)) wb_cnt_q <= wb_cnt_q + 32'd1;
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
  assign wb_cnt_o   = wb_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb/tb_dcache_ctrl.sv - self-checking bench for dcache_ctrl
module tb_dcache_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] cpu_addr;
  logic        cpu_rd;
  logic        cpu_wr;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_be;
  logic [31:0] cpu_rdata_o;
  logic        dcache_miss_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata;
  logic        mem_ack;
`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt_o;
  logic [31:0] miss_cnt_o;
  logic [31:0] wb_cnt_o;
`endif

  always #5 clk = ~clk;

  dcache_ctrl dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .cpu_addr_i   (cpu_addr),
    .cpu_rd_i     (cpu_rd),
    .cpu_wr_i     (cpu_wr),
    .cpu_wdata_i  (cpu_wdata),
    .cpu_be_i     (cpu_be),
    .mem_rdata_i  (mem_rdata),
    .mem_ack_i    (mem_ack),
    .cpu_rdata_o  (cpu_rdata_o),
`ifdef DCACHE_STATS_EN
    .hit_cnt_o    (hit_cnt_o),
    .miss_cnt_o   (miss_cnt_o),
    .wb_cnt_o     (wb_cnt_o),
`endif
    .dcache_miss_o(dcache_miss_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o)
  );

  // Memory model: word[i] = i*4, acks after ack_delay wait cycles per beat.
  logic [31:0] mem [0:4095];
  int          ack_delay = 0;
  int          wait_cnt  = 0;
  int          stab_err  = 0;
  logic [31:0] hold_addr, hold_wdata;
  logic        hold_we;
  logic [31:0] wb_addr[$];
  logic [31:0] wb_data[$];
  logic [31:0] fill_addr[$];

  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
  end

  always @(negedge clk) begin
    if (mem_req_o) begin
      if (wait_cnt == 0) begin
        hold_addr  = mem_addr_o;
        hold_we    = mem_we_o;
        hold_wdata = mem_wdata_o;
      end else if (mem_addr_o !== hold_addr || mem_we_o !== hold_we ||
                   (hold_we && mem_wdata_o !== hold_wdata)) begin
        stab_err++;
      end
      if (wait_cnt >= ack_delay) begin
        mem_ack   = 1'b1;
        mem_rdata = mem[mem_addr_o[13:2]];
        if (mem_we_o) begin
          mem[mem_addr_o[13:2]] = mem_wdata_o;
          wb_addr.push_back(mem_addr_o);
          wb_data.push_back(mem_wdata_o);
        end else begin
          fill_addr.push_back(mem_addr_o);
        end
        wait_cnt = 0;
      end else begin
        mem_ack = 1'b0;
        wait_cnt++;
      end
    end else begin
      if (wait_cnt != 0) stab_err++;
      mem_ack  = 1'b0;
      wait_cnt = 0;
    end
  end

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic clear_logs();
    wb_addr.delete();
    wb_data.delete();
    fill_addr.delete();
    stab_err = 0;
  endtask

  task automatic access(input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        output int stall, output logic [31:0] rdata, output logic req_at_done);
    bit done;
    done        = 1'b0;
    stall       = 0;
    rdata       = '0;
    req_at_done = 1'b1;
    @(posedge clk); #1;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    cpu_be    = be;
    cpu_rd    = rd;
    cpu_wr    = wr;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (!dcache_miss_o) begin
        rdata       = cpu_rdata_o;
        req_at_done = mem_req_o;
        done        = 1'b1;
        break;
      end
      stall++;
    end
    if (!done) begin
      n_total++;
      $display("FAIL access_timeout: addr %h still stalled after %0d cycles", addr, stall);
    end
    @(posedge clk); #1;
    cpu_rd = 1'b0;
    cpu_wr = 1'b0;
  endtask

  function automatic logic [31:0] seq_ok(input logic [31:0] q[$], input logic [31:0] base);
    logic [31:0] ok;
    ok = 32'd1;
    for (int k = 0; k < q.size(); k++) if (q[k] !== base + 32'(4 * k)) ok = 32'd0;
    return ok;
  endfunction

  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          dly;
    int          exp_stall;
    bit          chk_rdata;
    logic [31:0] exp_rdata;
    int          exp_wb;
    logic [31:0] wb_base;
    logic [31:0] wb1_data;
    int          exp_fill;
    logic [31:0] fill_base;
  } vec_t;

  vec_t vecs[12];

  int          stall;
  logic [31:0] rdata;
  logic        req_done;
  logic [31:0] found;

  initial begin
    vecs[0]  = '{1, 0, 32'h010, 32'h0,        4'h0, 0, 6,  1, 32'h0000_0010, 0, 32'h0,   32'h0,        4, 32'h010};
    vecs[1]  = '{0, 1, 32'h014, 32'hDEADBEEF, 4'h3, 0, 0,  0, 32'h0,         0, 32'h0,   32'h0,        0, 32'h0};
    vecs[2]  = '{1, 0, 32'h014, 32'h0,        4'h0, 0, 0,  1, 32'h0000_BEEF, 0, 32'h0,   32'h0,        0, 32'h0};
    vecs[3]  = '{1, 0, 32'h414, 32'h0,        4'h0, 0, 10, 1, 32'h0000_0414, 4, 32'h010, 32'h0000BEEF, 4, 32'h410};
    vecs[4]  = '{1, 0, 32'h820, 32'h0,        4'h0, 3, 18, 1, 32'h0000_0820, 0, 32'h0,   32'h0,        4, 32'h820};
    vecs[5]  = '{0, 1, 32'h824, 32'h12345678, 4'hF, 0, 0,  0, 32'h0,         0, 32'h0,   32'h0,        0, 32'h0};
    vecs[6]  = '{1, 1, 32'h828, 32'hA5A5A5A5, 4'hC, 0, 0,  0, 32'h0,         0, 32'h0,   32'h0,        0, 32'h0};
    vecs[7]  = '{1, 0, 32'h828, 32'h0,        4'h0, 0, 0,  1, 32'hA5A5_0828, 0, 32'h0,   32'h0,        0, 32'h0};
    vecs[8]  = '{1, 0, 32'h014, 32'h0,        4'h0, 0, 6,  1, 32'h0000_BEEF, 0, 32'h0,   32'h0,        4, 32'h010};
    vecs[9]  = '{1, 0, 32'h024, 32'h0,        4'h0, 0, 10, 1, 32'h0000_0024, 4, 32'h820, 32'h12345678, 4, 32'h020};
    vecs[10] = '{1, 0, 32'h828, 32'h0,        4'h0, 0, 6,  1, 32'hA5A5_0828, 0, 32'h0,   32'h0,        4, 32'h820};
    vecs[11] = '{1, 0, 32'h010, 32'h0,        4'h0, 0, 0,  1, 32'h0000_0010, 0, 32'h0,   32'h0,        0, 32'h0};

    for (int i = 0; i < 4096; i++) mem[i] = 32'(i * 4);

    rst_n     = 1'b0;
    cpu_addr  = '0;
    cpu_rd    = 1'b0;
    cpu_wr    = 1'b0;
    cpu_wdata = '0;
    cpu_be    = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_mem_req",   32'(mem_req_o),     32'd0);
    check("reset_mem_we",    32'(mem_we_o),      32'd0);
    check("reset_mem_addr",  mem_addr_o,         32'd0);
    check("reset_mem_wdata", mem_wdata_o,        32'd0);
    check("reset_miss",      32'(dcache_miss_o), 32'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      clear_logs();
      ack_delay = vecs[i].dly;
      access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be, stall, rdata, req_done);
      check($sformatf("v%0d_stall", i), 32'(stall), 32'(vecs[i].exp_stall));
      check($sformatf("v%0d_req_idle", i), 32'(req_done), 32'd0);
      if (vecs[i].chk_rdata) check($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rdata);
      check($sformatf("v%0d_wb_beats", i), 32'(wb_addr.size()), 32'(vecs[i].exp_wb));
      if (vecs[i].exp_wb > 0) begin
        check($sformatf("v%0d_wb_addrs", i), seq_ok(wb_addr, vecs[i].wb_base), 32'd1);
        check($sformatf("v%0d_wb_beat1", i), wb_data[1], vecs[i].wb1_data);
      end
      check($sformatf("v%0d_fill_beats", i), 32'(fill_addr.size()), 32'(vecs[i].exp_fill));
      if (vecs[i].exp_fill > 0)
        check($sformatf("v%0d_fill_addrs", i), seq_ok(fill_addr, vecs[i].fill_base), 32'd1);
      check($sformatf("v%0d_stable", i), 32'(stab_err), 32'd0);
    end

    // Reset asserted while the third refill beat is on the bus.
    clear_logs();
    ack_delay = 0;
    @(posedge clk); #1;
    cpu_addr = 32'h030;
    cpu_rd   = 1'b1;
    found    = 32'd0;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk); #2;
      if (fill_addr.size() == 2 && mem_req_o) begin
        found = 32'd1;
        break;
      end
    end
    check("rst_mid_reached", found, 32'd1);
    check("rst_mid_beat3_addr", mem_addr_o, 32'h038);
    rst_n = 1'b0;
    #1;
    check("rst_mid_req_drop", 32'(mem_req_o), 32'd0);
    check("rst_mid_miss_held", 32'(dcache_miss_o), 32'd1);
    cpu_rd = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    clear_logs();
    access(1'b1, 1'b0, 32'h030, 32'h0, 4'h0, stall, rdata, req_done);
    check("post_rst_stall", 32'(stall), 32'd6);
    check("post_rst_fill_beats", 32'(fill_addr.size()), 32'd4);
    check("post_rst_fill_addrs", seq_ok(fill_addr, 32'h030), 32'd1);
    check("post_rst_rdata", rdata, 32'h0000_0030);

    clear_logs();
    access(1'b1, 1'b0, 32'h010, 32'h0, 4'h0, stall, rdata, req_done);
    check("post_rst_inval_stall", 32'(stall), 32'd6);
    check("post_rst_inval_wb", 32'(wb_addr.size()), 32'd0);
    check("post_rst_inval_rdata", rdata, 32'h0000_0010);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
